// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arb_pkg
//  Description : Shared types and constants for the SRAM port arbiter:
//                FSM state encoding, port-owner encoding and the width of
//                the phase (wait-state) counter.
//  Revision    : 1.0  initial release
// ============================================================================
package sram_arb_pkg;

    // Transaction sequencer: grant, low half-word, high half-word, complete
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    // Which requester currently owns the SRAM
    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_t;

    // Phase counter width; WAIT_CYCLES must fit in this many bits
    localparam int unsigned c_phase_cnt_w = 8;

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/sram_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sram_phase_timer
//  Description : Loadable down-counter timing one half-word SRAM phase.
//                A phase lasts WAIT_CYCLES+1 cycles after a load.
//                o_phase_last is high on the final cycle of the phase,
//                o_phase_we on every cycle before it (write-enable window).
//  Revision    : 1.0  initial release
// ============================================================================
module sram_phase_timer
    import sram_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_phase_last,
    output logic o_phase_we
);

    localparam logic [c_phase_cnt_w-1:0] c_load_val = c_phase_cnt_w'(WAIT_CYCLES);

    logic [c_phase_cnt_w-1:0] r_cnt;

    // Reload at the start of each phase, then count down and park at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_phase_last = (r_cnt == '0);
    assign o_phase_we   = (r_cnt != '0);

endmodule : sram_phase_timer
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_port_arbiter
//  Description : Shares one 16-bit asynchronous SRAM between the instruction
//                fetch port (IF) and the data port (MEM). Every 32-bit access
//                is split into a low and a high half-word phase, each lasting
//                WAIT_CYCLES+1 cycles. Requesters are stalled through
//                *_not_ready until their access reaches the DONE cycle.
//  Config      : SRAM_ARB_ROUND_ROBIN_EN - when defined, ties alternate
//                between ports (last-served loses); otherwise MEM always
//                wins a tie.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_not_ready,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_not_ready,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N
);

    localparam logic [31:0] c_base = 32'(BASE_ADDR);

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    arb_owner_t  r_owner;
    arb_owner_t  w_grant;
    logic        r_is_write;
    logic [16:0] r_widx;
    logic [31:0] r_wdata;
    logic [15:0] r_lo_half;
    logic [31:0] r_mem_rdata;
    logic [31:0] r_if_rdata;

    logic        w_mem_req;
    logic        w_if_req;
    logic        w_any_req;
    logic        w_grant_now;
    logic        w_in_phase;
    logic        w_phase_last;
    logic        w_phase_we;
    logic        w_timer_load;
    logic        w_dq_oe;
    logic [31:0] w_mem_off;
    logic [31:0] w_if_off;
    logic        w_unused_addr_bits;

    assign w_mem_req   = mem_read | mem_write;
    assign w_if_req    = if_req;
    assign w_any_req   = w_mem_req | w_if_req;
    assign w_grant_now = (r_state == ST_IDLE) && w_any_req;
    assign w_in_phase  = (r_state == ST_LO) || (r_state == ST_HI);

    // Byte address -> SRAM word index; the two low bits are the byte lane
    assign w_mem_off = mem_addr - c_base;
    assign w_if_off  = if_addr - c_base;
    assign w_unused_addr_bits = ^{w_mem_off[31:19], w_mem_off[1:0],
                                  w_if_off[31:19], w_if_off[1:0]};

    // A new phase starts on the grant and on the LO->HI hand-over
    assign w_timer_load = w_grant_now || ((r_state == ST_LO) && w_phase_last);

    sram_phase_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_phase_timer (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_timer_load),
        .o_phase_last (w_phase_last),
        .o_phase_we   (w_phase_we)
    );

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    arb_owner_t r_last_served;

    // Remember who was granted last so that port loses the next tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_served <= OWN_IF;
        end else if (w_grant_now) begin
            r_last_served <= w_grant;
        end
    end
`endif

    // Pick the winning port for a grant taken in IDLE
    always_comb begin
        w_grant = OWN_IF;
        if (w_mem_req && w_if_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            w_grant = (r_last_served == OWN_MEM) ? OWN_IF : OWN_MEM;
`else
            w_grant = OWN_MEM;
`endif
        end else if (w_mem_req) begin
            w_grant = OWN_MEM;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer next state: each half-word phase ends on the timer's last cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req)    w_state_nxt = ST_LO;
            ST_LO:   if (w_phase_last) w_state_nxt = ST_HI;
            ST_HI:   if (w_phase_last) w_state_nxt = ST_DONE;
            ST_DONE:                   w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch the granted request and assemble read data from the two halves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner     <= OWN_IF;
            r_is_write  <= 1'b0;
            r_widx      <= '0;
            r_wdata     <= '0;
            r_lo_half   <= '0;
            r_mem_rdata <= '0;
            r_if_rdata  <= '0;
        end else begin
            if (w_grant_now) begin
                r_owner    <= w_grant;
                r_is_write <= (w_grant == OWN_MEM) && mem_write;
                r_widx     <= (w_grant == OWN_MEM) ? w_mem_off[18:2] : w_if_off[18:2];
                r_wdata    <= mem_wdata;
            end
            if ((r_state == ST_LO) && w_phase_last && !r_is_write) begin
                r_lo_half <= SRAM_DQ;
            end
            // A requester that withdrew mid-access does not get the result
            if ((r_state == ST_HI) && w_phase_last && !r_is_write) begin
                if ((r_owner == OWN_MEM) && w_mem_req) begin
                    r_mem_rdata <= {SRAM_DQ, r_lo_half};
                end
                if ((r_owner == OWN_IF) && w_if_req) begin
                    r_if_rdata <= {SRAM_DQ, r_lo_half};
                end
            end
        end
    end

    // SRAM pins are decoded from registered state so reset clears them at once.
    // WE_N rises on the last phase cycle so address and data outlive the strobe.
    assign SRAM_ADDR = {r_widx, (r_state == ST_HI)};
    assign SRAM_OE_N = ~(w_in_phase && !r_is_write);
    assign SRAM_WE_N = ~(w_in_phase && r_is_write && w_phase_we);
    assign w_dq_oe   = w_in_phase && r_is_write && (r_owner == OWN_MEM);
    assign SRAM_DQ   = w_dq_oe ? ((r_state == ST_HI) ? r_wdata[31:16] : r_wdata[15:0])
                               : 16'hzzzz;

    // Stall until the DONE cycle of this port's own access
    assign mem_not_ready = w_mem_req && !((r_state == ST_DONE) && (r_owner == OWN_MEM));
    assign if_not_ready  = w_if_req  && !((r_state == ST_DONE) && (r_owner == OWN_IF));

    assign mem_rdata = r_mem_rdata;
    assign if_rdata  = r_if_rdata;

endmodule : sram_port_arbiter
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_port_arbiter
//  Description : Self-checking bench for sram_port_arbiter. A behavioural
//                SRAM array sits on the pins; a word-level reference memory
//                predicts read data. Random single-port traffic plus directed
//                contention, reset-abort and withdrawn-request scenarios.
//  Config      : honours SRAM_ARB_ROUND_ROBIN_EN for tie expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sram_port_arbiter;

    localparam int TB_BASE = 1024;
    localparam int TB_WAIT = 1;
    localparam int LAT     = 1 + 2 * (TB_WAIT + 1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_not_ready;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_not_ready;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_we_n;
    logic        sram_oe_n;

    logic [15:0] sram_mem [0:262143];
    logic [31:0] ref_word [0:127];
    bit          preloaded = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    sram_port_arbiter #(
        .BASE_ADDR   (TB_BASE),
        .WAIT_CYCLES (TB_WAIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_not_ready (mem_not_ready),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_rdata      (if_rdata),
        .if_not_ready  (if_not_ready),
        .SRAM_ADDR     (sram_addr),
        .SRAM_DQ       (sram_dq),
        .SRAM_WE_N     (sram_we_n),
        .SRAM_OE_N     (sram_oe_n)
    );

    always #5 clk = ~clk;

    // Initial SRAM contents; words 2/3 hold the fetch pattern
    function automatic logic [15:0] pat(input int i);
        if (i == 2) return 16'h5678;
        if (i == 3) return 16'h1234;
        return 16'((i * 40503) ^ 23130);
    endfunction

    function automatic logic [31:0] waddr(input int w);
        return 32'(TB_BASE + 4 * w);
    endfunction

    // Asynchronous SRAM: drives the bus while OE_N is low, stores while WE_N is low
    assign sram_dq = sram_oe_n ? 16'hzzzz : sram_mem[sram_addr];

    always @(negedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= pat(i);
            preloaded <= 1'b1;
        end else if (!sram_we_n) begin
            sram_mem[sram_addr] <= sram_dq;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One single-port access; starts and ends at posedge+1 in IDLE
    task automatic run_txn(input bit is_if, input bit is_wr, input int w, input logic [31:0] wd);
        int lat = -1;
        int both_low = 0;
        int we_low = 0;
        int oe_low = 0;
        logic [17:0] a_first = '1;
        logic [17:0] a_last = '1;
        bit seen = 1'b0;
        if (is_if) begin
            if_req  = 1'b1;
            if_addr = waddr(w);
        end else begin
            mem_write = is_wr;
            mem_read  = !is_wr;
            mem_addr  = waddr(w);
            mem_wdata = wd;
        end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!sram_we_n && !sram_oe_n) both_low++;
            if (!sram_we_n) we_low++;
            if (!sram_oe_n) oe_low++;
            if (!sram_we_n || !sram_oe_n) begin
                if (!seen) a_first = sram_addr;
                a_last = sram_addr;
                seen = 1'b1;
            end
            if (!(is_if ? if_not_ready : mem_not_ready)) begin
                lat = k;
                if (!is_wr) chk(is_if ? "if_rdata" : "mem_rdata",
                                is_if ? if_rdata : mem_rdata, ref_word[w]);
                break;
            end
            @(posedge clk); #1;
            // Inputs other than the request level must not disturb the access
            if (k == 0) begin
                mem_addr  = $urandom;
                mem_wdata = $urandom;
                if_addr   = $urandom;
            end
        end
        chk("latency", lat, LAT);
        chk("we_oe_overlap", both_low, 0);
        chk("addr_first", a_first, 18'(2 * w));
        chk("addr_last", a_last, 18'(2 * w + 1));
        if (is_wr) begin
            chk("wr_oe_low", oe_low, 0);
            chk("wr_we_cycles", we_low, 2 * TB_WAIT);
        end else begin
            chk("rd_we_low", we_low, 0);
            chk("rd_oe_cycles", oe_low, 2 * (TB_WAIT + 1));
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0; if_req = 1'b0;
        if (is_wr) begin
            chk("sram_lo", sram_mem[2 * w], wd[15:0]);
            chk("sram_hi", sram_mem[2 * w + 1], wd[31:16]);
            ref_word[w] = wd;
        end
    endtask

    // MEM and IF read in the same cycle; MEM keeps requesting for mem_txns accesses
    task automatic tie_run(input int mem_txns, input int w_mem, input int w_if,
                           output int md0, output int md1, output int ifd);
        int n_m = 0;
        bit drop_m;
        bit drop_i;
        md0 = -1; md1 = -1; ifd = -1;
        mem_read = 1'b1; mem_addr = waddr(w_mem);
        if_req   = 1'b1; if_addr  = waddr(w_if);
        for (int k = 0; k < 40; k++) begin
            drop_m = 1'b0; drop_i = 1'b0;
            @(negedge clk);
            if (mem_read && !mem_not_ready) begin
                chk("tie_mem_rdata", mem_rdata, ref_word[w_mem]);
                if (n_m == 0) md0 = k; else md1 = k;
                n_m++;
                if (n_m >= mem_txns) drop_m = 1'b1;
            end
            if (if_req && !if_not_ready) begin
                chk("tie_if_rdata", if_rdata, ref_word[w_if]);
                ifd = k;
                drop_i = 1'b1;
            end
            @(posedge clk); #1;
            if (drop_m) mem_read = 1'b0;
            if (drop_i) if_req = 1'b0;
            if (!mem_read && !if_req) break;
        end
        mem_read = 1'b0; if_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int md0, md1, ifd, nr_bad;
        logic [31:0] wd;
        for (int w = 0; w < 128; w++) ref_word[w] = {pat(2 * w + 1), pat(2 * w)};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we_n", sram_we_n, 1'b1);
        chk("rst_oe_n", sram_oe_n, 1'b1);
        chk("rst_addr", sram_addr, 18'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_not_ready", {mem_not_ready, if_not_ready}, 2'b00);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Directed: write/readback at the base address, then an IF fetch
        run_txn(1'b0, 1'b1, 0, 32'hDEADBEEF);
        run_txn(1'b0, 1'b0, 0, 32'h0);
        run_txn(1'b1, 1'b0, 1, 32'h0);

        // Random single-port traffic
        for (int i = 0; i < 30; i++) begin
            int op = $urandom_range(0, 2);
            int w  = $urandom_range(0, 15);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            run_txn(op == 2, op == 0, w, $urandom);
        end

        // Reset during the HI phase of a write aborts immediately
        mem_write = 1'b1; mem_addr = waddr(100); mem_wdata = $urandom;
        repeat (4) @(negedge clk);
        chk("abort_setup", {sram_addr[0], sram_we_n}, 2'b10);
        #1 rst = 1'b1;
        #1;
        chk("abort_we_n", sram_we_n, 1'b1);
        chk("abort_oe_n", sram_oe_n, 1'b1);
        chk("abort_addr", sram_addr, 18'd0);
        chk("abort_rdata", mem_rdata, 32'd0);
        mem_write = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        run_txn(1'b0, 1'b0, 7, 32'h0);

        // Tie, MEM withdraws after its access: MEM then IF
        do_reset();
        tie_run(1, 3, 4, md0, md1, ifd);
        chk("tieA_mem_done", md0, LAT);
        chk("tieA_if_done", ifd, 2 * LAT + 1);

        // Tie, MEM keeps requesting: second tie decides who goes next
        do_reset();
        tie_run(2, 8, 9, md0, md1, ifd);
        chk("tieB_mem_first", md0, LAT);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        chk("tieB_if_done", ifd, 2 * LAT + 1);
        chk("tieB_mem_second", md1, 3 * LAT + 2);
`else
        chk("tieB_mem_second", md1, 2 * LAT + 1);
        chk("tieB_if_done", ifd, 3 * LAT + 2);
`endif

        // MEM write withdrawn in LO: write still completes, IF served next
        do_reset();
        wd = $urandom;
        nr_bad = 0; ifd = -1;
        mem_write = 1'b1; mem_addr = waddr(5); mem_wdata = wd;
        if_req = 1'b1; if_addr = waddr(6);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k >= 1 && mem_not_ready) nr_bad++;
            if (!if_not_ready) begin
                ifd = k;
                chk("drop_if_rdata", if_rdata, ref_word[6]);
                break;
            end
            @(posedge clk); #1;
            if (k == 0) mem_write = 1'b0;
        end
        @(posedge clk); #1;
        if_req = 1'b0;
        chk("drop_mem_nr", nr_bad, 0);
        chk("drop_if_done", ifd, 2 * LAT + 1);
        chk("drop_sram_lo", sram_mem[10], wd[15:0]);
        chk("drop_sram_hi", sram_mem[11], wd[31:16]);
        ref_word[5] = wd;
        run_txn(1'b0, 1'b0, 5, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case a loop above is somehow never left
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule : tb_sram_port_arbiter
`default_nettype wire
